// File: rtl/lut_prog_pkg.sv
// Shared types and default sizing for the programmable branch-target table.
// Loader state encoding, stream beat-count type and index-width helper.
package lut_pkg;

  localparam int LUT_LABEL_W    = 8;
  localparam int LUT_PC_W       = 12;
  localparam int LUT_DEPTH      = 64;
  localparam int LUT_DEFAULT_PC = 0;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_DONE = 2'd2
  } ld_state_e;

  typedef logic [LUT_LABEL_W:0] ld_cnt_t;

  function automatic int lut_idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/lut_prog_if.sv
// Lookup, single-write, clear and stream-load signals of the branch-target table.
// The master drives requests and beats; the slave (the table) returns results and handshakes.
interface lut_prog_if #(
  parameter int LABEL_W = lut_pkg::LUT_LABEL_W,
  parameter int PC_W    = lut_pkg::LUT_PC_W
) ();

  logic               rd_en;
  logic [LABEL_W-1:0] rd_label;
  logic               rd_valid;
  logic               rd_hit;
  logic [PC_W-1:0]    rd_target;

  logic               wr_en;
  logic [LABEL_W-1:0] wr_label;
  logic [PC_W-1:0]    wr_target;
  logic               wr_err;

  logic               clr;

  logic               ld_start;
  logic [LABEL_W-1:0] ld_base;
  logic [LABEL_W:0]   ld_count;
  logic               ld_valid;
  logic [PC_W-1:0]    ld_target;
  logic               ld_ready;
  logic               ld_busy;
  logic               ld_done;

  modport master (
    output rd_en, rd_label, wr_en, wr_label, wr_target, clr,
           ld_start, ld_base, ld_count, ld_valid, ld_target,
    input  rd_valid, rd_hit, rd_target, wr_err, ld_ready, ld_busy, ld_done
  );

  modport slave (
    input  rd_en, rd_label, wr_en, wr_label, wr_target, clr,
           ld_start, ld_base, ld_count, ld_valid, ld_target,
    output rd_valid, rd_hit, rd_target, wr_err, ld_ready, ld_busy, ld_done
  );

endinterface

// File: rtl/lut_prog_load_ctrl.sv
// Stream loader: turns a base/count plus valid/ready beats into table write strobes, zero latency.
// ld_ready drops whenever a port write is pending; clr aborts a load without a done pulse.
module lut_load_ctrl #(
  parameter int LABEL_W = lut_pkg::LUT_LABEL_W,
  parameter int PC_W    = lut_pkg::LUT_PC_W,
  parameter int DEPTH   = lut_pkg::LUT_DEPTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               wr_en_i,
  input  logic               ld_start_i,
  input  logic [LABEL_W-1:0] ld_base_i,
  input  logic [LABEL_W:0]   ld_count_i,
  input  logic               ld_valid_i,
  input  logic [PC_W-1:0]    ld_target_i,
  output logic               ld_ready_o,
  output logic               ld_busy_o,
  output logic               ld_done_o,
  output logic               beat_vld_o,
  output logic [LABEL_W-1:0] beat_idx_o,
  output logic [PC_W-1:0]    beat_dat_o
);
  import lut_pkg::*;

  localparam logic [LABEL_W-1:0] PTR_LAST = LABEL_W'(DEPTH - 1);
  localparam logic [LABEL_W:0]   REM_ONE  = (LABEL_W + 1)'(1);

  ld_state_e          state_q, state_d;
  logic [LABEL_W-1:0] ptr_q, ptr_d;
  logic [LABEL_W:0]   rem_q, rem_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LD_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rem_d      = rem_q;
    ld_ready_o = 1'b0;
    ld_busy_o  = 1'b0;
    ld_done_o  = 1'b0;
    beat_vld_o = 1'b0;
    unique case (state_q)
      LD_IDLE: begin
        if (ld_start_i) begin
          ptr_d   = ld_base_i;
          rem_d   = ld_count_i;
          state_d = (ld_count_i != '0) ? LD_LOAD : LD_DONE;
        end
      end
      LD_LOAD: begin
        ld_busy_o  = 1'b1;
        ld_ready_o = !wr_en_i;
        beat_vld_o = ld_valid_i && !wr_en_i;
        if (clr_i) begin
          state_d = LD_IDLE;
        end else if (beat_vld_o) begin
          // Out-of-range bases keep counting up and wrap at the field width.
          ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
          rem_d = rem_q - 1'b1;
          if (rem_q == REM_ONE) state_d = LD_DONE;
        end
      end
      LD_DONE: begin
        ld_done_o = !clr_i;
        state_d   = LD_IDLE;
      end
      default: state_d = LD_IDLE;
    endcase
  end

  assign beat_idx_o = ptr_q;
  assign beat_dat_o = ld_target_i;

endmodule

// File: rtl/lut_prog.sv
// Programmable label-to-PC table: one-cycle registered lookup with write-to-read bypass.
// Write priority clr > stream beat > port write; a port write stalls the stream via ld_ready.
module lut_prog #(
  parameter int LABEL_W    = lut_pkg::LUT_LABEL_W,
  parameter int PC_W       = lut_pkg::LUT_PC_W,
  parameter int DEPTH      = lut_pkg::LUT_DEPTH,
  parameter int DEFAULT_PC = lut_pkg::LUT_DEFAULT_PC
) (
  input logic       clk,
  input logic       rst_n,
  lut_prog_if.slave bus
);
  import lut_pkg::*;

  localparam int                 IDX_W = lut_idx_w(DEPTH);
  localparam logic [LABEL_W:0]   LIMIT = (LABEL_W + 1)'(DEPTH);
  localparam logic [PC_W-1:0]    DFLT  = PC_W'(DEFAULT_PC);

  logic               beat_vld;
  logic [LABEL_W-1:0] beat_idx;
  logic [PC_W-1:0]    beat_dat;

  logic               wr_go;
  logic [LABEL_W-1:0] wr_idx;
  logic [PC_W-1:0]    wr_dat;
  logic               wr_in_range;
  logic               wr_store;
  logic [IDX_W-1:0]   wr_slot;

  logic               rd_in_range;
  logic [IDX_W-1:0]   rd_slot;
  logic               rd_hit_d;
  logic [PC_W-1:0]    rd_tgt_d;

  logic [PC_W-1:0]    tgt_q [DEPTH];
  logic [DEPTH-1:0]   vld_q, vld_d;
  logic               rd_valid_q, rd_hit_q, wr_err_q;
  logic [PC_W-1:0]    rd_tgt_q;

  lut_load_ctrl #(
    .LABEL_W (LABEL_W),
    .PC_W    (PC_W),
    .DEPTH   (DEPTH)
  ) u_load (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (bus.clr),
    .wr_en_i     (bus.wr_en),
    .ld_start_i  (bus.ld_start),
    .ld_base_i   (bus.ld_base),
    .ld_count_i  (bus.ld_count),
    .ld_valid_i  (bus.ld_valid),
    .ld_target_i (bus.ld_target),
    .ld_ready_o  (bus.ld_ready),
    .ld_busy_o   (bus.ld_busy),
    .ld_done_o   (bus.ld_done),
    .beat_vld_o  (beat_vld),
    .beat_idx_o  (beat_idx),
    .beat_dat_o  (beat_dat)
  );

  always_comb begin
    wr_go  = 1'b0;
    wr_idx = bus.wr_label;
    wr_dat = bus.wr_target;
    if (!bus.clr) begin
      if (beat_vld) begin
        wr_go  = 1'b1;
        wr_idx = beat_idx;
        wr_dat = beat_dat;
      end else if (bus.wr_en) begin
        wr_go = 1'b1;
      end
    end
  end

  assign wr_in_range = ({1'b0, wr_idx} < LIMIT);
  assign wr_store    = wr_go && wr_in_range;
  assign wr_slot     = wr_idx[IDX_W-1:0];
  assign rd_in_range = ({1'b0, bus.rd_label} < LIMIT);
  assign rd_slot     = bus.rd_label[IDX_W-1:0];

  always_comb begin
    vld_d = vld_q;
    if (bus.clr) vld_d = '0;
    else if (wr_store) vld_d[wr_slot] = 1'b1;
  end

  // Lookups see this cycle's clear/write, so hit comes from vld_d and data is forwarded.
  always_comb begin
    rd_hit_d = rd_in_range && vld_d[rd_slot];
    rd_tgt_d = DFLT;
    if (rd_hit_d) rd_tgt_d = (wr_store && (wr_slot == rd_slot)) ? wr_dat : tgt_q[rd_slot];
  end

  always_ff @(posedge clk) begin
    if (wr_store) tgt_q[wr_slot] <= wr_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_hit_q   <= 1'b0;
      rd_tgt_q   <= DFLT;
      wr_err_q   <= 1'b0;
    end else begin
      vld_q      <= vld_d;
      rd_valid_q <= bus.rd_en;
      wr_err_q   <= wr_go && !wr_in_range;
      if (bus.rd_en) begin
        rd_hit_q <= rd_hit_d;
        rd_tgt_q <= rd_tgt_d;
      end
    end
  end

  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_hit    = rd_hit_q;
  assign bus.rd_target = rd_tgt_q;
  assign bus.wr_err    = wr_err_q;

endmodule

// File: tb/tb_lut_prog.sv
// Bench for lut_prog: directed scenarios plus a randomized run against a table model.
module tb_lut_prog;
  import lut_pkg::*;

  localparam int DEPTH = LUT_DEPTH;
  localparam int NLBL  = 1 << LUT_LABEL_W;
  typedef logic [LUT_PC_W-1:0] pc_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lut_prog_if bus ();

  lut_prog dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: table contents and loader progress as plain arrays/ints.
  bit  m_vld [NLBL];
  pc_t m_tgt [NLBL];
  bit  m_active, m_finishing;
  int  m_ptr, m_rem;
  bit  e_rv, e_hit, e_err;
  pc_t e_tgt;

  task automatic idle_inputs();
    bus.rd_en = 0; bus.rd_label = '0; bus.wr_en = 0; bus.wr_label = '0; bus.wr_target = '0;
    bus.clr = 0; bus.ld_start = 0; bus.ld_base = '0; bus.ld_count = '0;
    bus.ld_valid = 0; bus.ld_target = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NLBL; i++) m_vld[i] = 0;
    m_active = 0; m_finishing = 0; m_ptr = 0; m_rem = 0;
    e_rv = 0; e_hit = 0; e_err = 0; e_tgt = pc_t'(LUT_DEFAULT_PC);
  endtask

  // Apply the current inputs to the model, then advance one clock.
  task automatic step();
    bit acc, wgo;
    int widx;
    pc_t wdat;
    acc = m_active && bus.ld_valid && !bus.wr_en;
    wgo = 0; widx = 0; wdat = '0;
    if (bus.clr) begin
      for (int i = 0; i < NLBL; i++) m_vld[i] = 0;
    end else if (acc) begin
      wgo = 1; widx = m_ptr; wdat = bus.ld_target;
    end else if (bus.wr_en) begin
      wgo = 1; widx = int'(bus.wr_label); wdat = bus.wr_target;
    end
    if (wgo && widx < DEPTH) begin m_vld[widx] = 1; m_tgt[widx] = wdat; end
    e_err = wgo && (widx >= DEPTH);
    e_rv  = bus.rd_en;
    if (bus.rd_en) begin
      e_hit = (int'(bus.rd_label) < DEPTH) && m_vld[bus.rd_label];
      e_tgt = e_hit ? m_tgt[bus.rd_label] : pc_t'(LUT_DEFAULT_PC);
    end
    if (bus.clr && (m_active || m_finishing)) begin
      m_active = 0; m_finishing = 0;
    end else if (m_finishing) begin
      m_finishing = 0;
    end else if (m_active) begin
      if (acc) begin
        m_ptr = (m_ptr == DEPTH - 1) ? 0 : (m_ptr + 1) % NLBL;
        m_rem = m_rem - 1;
        if (m_rem == 0) begin m_active = 0; m_finishing = 1; end
      end
    end else if (bus.ld_start) begin
      m_ptr = int'(bus.ld_base); m_rem = int'(bus.ld_count);
      if (m_rem == 0) m_finishing = 1; else m_active = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input int base, input ld_cnt_t cnt);
    bus.ld_start = 1; bus.ld_base = LUT_LABEL_W'(base); bus.ld_count = cnt;
    step();
    bus.ld_start = 0;
  endtask

  task automatic send_beat(input pc_t t, output bit ok);
    bus.ld_valid = 1; bus.ld_target = t; ok = 0;
    for (int k = 0; k < 16 && !ok; k++) begin
      #1;
      ok = (bus.ld_ready === 1'b1);
      step();
    end
    bus.ld_valid = 0;
  endtask

  task automatic test_reset();
    idle_inputs(); model_reset(); rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if ({bus.rd_valid, bus.rd_hit, bus.wr_err, bus.ld_ready, bus.ld_busy, bus.ld_done} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000000", {bus.rd_valid, bus.rd_hit, bus.wr_err, bus.ld_ready, bus.ld_busy, bus.ld_done}); end
    n_tests++; if (bus.rd_target !== pc_t'(LUT_DEFAULT_PC)) begin
      n_fail++; $display("FAIL reset_target: got %0d want %0d", bus.rd_target, LUT_DEFAULT_PC); end
    rst_n = 1;
    step();
    bus.rd_en = 1; bus.rd_label = 8'd2;
    step(); idle_inputs();
    n_tests++; if ({bus.rd_valid, bus.rd_hit} !== 2'b10 || bus.rd_target !== 12'd0) begin
      n_fail++; $display("FAIL reset_read2: got v=%b h=%b t=%0d want v=1 h=0 t=0", bus.rd_valid, bus.rd_hit, bus.rd_target); end
  endtask

  task automatic test_write_bypass();
    bus.wr_en = 1; bus.wr_label = 8'd2; bus.wr_target = 12'd352;
    bus.rd_en = 1; bus.rd_label = 8'd2;
    step(); idle_inputs();
    n_tests++; if ({bus.rd_valid, bus.rd_hit} !== 2'b11 || bus.rd_target !== 12'd352) begin
      n_fail++; $display("FAIL bypass_read: got v=%b h=%b t=%0d want v=1 h=1 t=352", bus.rd_valid, bus.rd_hit, bus.rd_target); end
    bus.rd_en = 1; bus.rd_label = 8'd3;
    step(); idle_inputs();
    n_tests++; if (bus.rd_hit !== 1'b0 || bus.rd_target !== 12'd0) begin
      n_fail++; $display("FAIL miss_label3: got h=%b t=%0d want h=0 t=0", bus.rd_hit, bus.rd_target); end
  endtask

  task automatic test_stream();
    bit ok1, ok2, ok3;
    pc_t exp_t [3] = '{12'd8, 12'd22, 12'd37};
    int dones = 0;
    start_load(18, ld_cnt_t'(3));
    n_tests++; if (bus.ld_busy !== 1'b1) begin n_fail++; $display("FAIL stream_busy: got %b want 1", bus.ld_busy); end
    send_beat(12'd8, ok1);  dones += int'(bus.ld_done);
    send_beat(12'd22, ok2); dones += int'(bus.ld_done);
    step();                 dones += int'(bus.ld_done);
    send_beat(12'd37, ok3);
    n_tests++; if (!(ok1 && ok2 && ok3)) begin n_fail++; $display("FAIL stream_handshake: got accepts %b%b%b want 111", ok1, ok2, ok3); end
    n_tests++; if (bus.ld_done !== 1'b1 || dones != 0) begin
      n_fail++; $display("FAIL stream_done: got done=%b early=%0d want done=1 early=0", bus.ld_done, dones); end
    step();
    n_tests++; if (bus.ld_done !== 1'b0 || bus.ld_busy !== 1'b0) begin
      n_fail++; $display("FAIL stream_after: got done=%b busy=%b want 0 0", bus.ld_done, bus.ld_busy); end
    for (int i = 0; i < 3; i++) begin
      bus.rd_en = 1; bus.rd_label = LUT_LABEL_W'(18 + i);
      step(); idle_inputs();
      n_tests++; if (bus.rd_hit !== 1'b1 || bus.rd_target !== exp_t[i]) begin
        n_fail++; $display("FAIL stream_entry%0d: got h=%b t=%0d want h=1 t=%0d", 18 + i, bus.rd_hit, bus.rd_target, exp_t[i]); end
    end
  endtask

  task automatic test_wrap();
    bit ok, all_ok;
    int  lbl [5] = '{62, 63, 0, 1, 2};
    pc_t val [5] = '{12'd1, 12'd2, 12'd3, 12'd4, 12'd0};
    bus.clr = 1; step(); idle_inputs();
    start_load(62, ld_cnt_t'(4));
    all_ok = 1;
    for (int i = 1; i <= 4; i++) begin send_beat(pc_t'(i), ok); all_ok &= ok; end
    n_tests++; if (!all_ok || bus.ld_done !== 1'b1) begin
      n_fail++; $display("FAIL wrap_done: got ok=%b done=%b want 1 1", all_ok, bus.ld_done); end
    for (int i = 0; i < 5; i++) begin
      bus.rd_en = 1; bus.rd_label = LUT_LABEL_W'(lbl[i]);
      step(); idle_inputs();
      n_tests++; if (bus.rd_hit !== (i < 4) || bus.rd_target !== val[i]) begin
        n_fail++; $display("FAIL wrap_entry%0d: got h=%b t=%0d want h=%b t=%0d", lbl[i], bus.rd_hit, bus.rd_target, i < 4, val[i]); end
    end
  endtask

  task automatic test_stall();
    bit ok1, ok2, ok3;
    pc_t a, b, c, d;
    int  lbl [4] = '{40, 41, 42, 5};
    pc_t val [4];
    a = pc_t'($urandom_range(1, 4095)); b = pc_t'($urandom_range(1, 4095));
    c = pc_t'($urandom_range(1, 4095)); d = pc_t'($urandom_range(1, 4095));
    val = '{a, b, d, c};
    start_load(40, ld_cnt_t'(3));
    send_beat(a, ok1);
    bus.ld_valid = 1; bus.ld_target = b;
    bus.wr_en = 1; bus.wr_label = 8'd5; bus.wr_target = c;
    #1;
    n_tests++; if (bus.ld_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready: got %b want 0", bus.ld_ready); end
    step();
    bus.wr_en = 0;
    send_beat(b, ok2);
    send_beat(d, ok3);
    n_tests++; if (!(ok1 && ok2 && ok3) || bus.ld_done !== 1'b1) begin
      n_fail++; $display("FAIL stall_done: got ok=%b%b%b done=%b want 111 1", ok1, ok2, ok3, bus.ld_done); end
    step();
    for (int i = 0; i < 4; i++) begin
      bus.rd_en = 1; bus.rd_label = LUT_LABEL_W'(lbl[i]);
      step(); idle_inputs();
      n_tests++; if (bus.rd_hit !== 1'b1 || bus.rd_target !== val[i]) begin
        n_fail++; $display("FAIL stall_entry%0d: got h=%b t=%0d want h=1 t=%0d", lbl[i], bus.rd_hit, bus.rd_target, val[i]); end
    end
  endtask

  task automatic test_clr_abort();
    bit ok1, ok2;
    start_load(10, ld_cnt_t'(4));
    send_beat(12'd100, ok1);
    send_beat(12'd200, ok2);
    bus.clr = 1; step(); idle_inputs();
    n_tests++; if (!(ok1 && ok2) || bus.ld_busy !== 1'b0 || bus.ld_done !== 1'b0) begin
      n_fail++; $display("FAIL abort_state: got ok=%b%b busy=%b done=%b want 11 0 0", ok1, ok2, bus.ld_busy, bus.ld_done); end
    bus.ld_valid = 1; bus.ld_target = 12'd7;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_tests++; if (bus.ld_ready !== 1'b0 || bus.ld_done !== 1'b0) begin
        n_fail++; $display("FAIL abort_idle%0d: got ready=%b done=%b want 0 0", k, bus.ld_ready, bus.ld_done); end
      step();
    end
    idle_inputs();
    for (int i = 0; i < NLBL; i++) begin
      bus.rd_en = 1; bus.rd_label = LUT_LABEL_W'(i);
      step(); idle_inputs();
      n_tests++; if (bus.rd_hit !== 1'b0 || bus.rd_target !== 12'd0) begin
        n_fail++; $display("FAIL abort_miss%0d: got h=%b t=%0d want h=0 t=0", i, bus.rd_hit, bus.rd_target); end
    end
  endtask

  task automatic test_err();
    bit ok;
    bus.wr_en = 1; bus.wr_label = 8'd70; bus.wr_target = 12'd5;
    bus.rd_en = 1; bus.rd_label = 8'd70;
    step(); idle_inputs();
    n_tests++; if (bus.wr_err !== 1'b1 || bus.rd_hit !== 1'b0) begin
      n_fail++; $display("FAIL err70: got err=%b h=%b want 1 0", bus.wr_err, bus.rd_hit); end
    step();
    n_tests++; if (bus.wr_err !== 1'b0) begin n_fail++; $display("FAIL err_pulse: got %b want 0", bus.wr_err); end
    bus.wr_en = 1; bus.wr_label = 8'd63; bus.wr_target = 12'd4000;
    step(); idle_inputs();
    bus.wr_en = 1; bus.wr_label = 8'd64; bus.wr_target = 12'd9;
    bus.rd_en = 1; bus.rd_label = 8'd63;
    step(); idle_inputs();
    n_tests++; if (bus.wr_err !== 1'b1 || bus.rd_hit !== 1'b1 || bus.rd_target !== 12'd4000) begin
      n_fail++; $display("FAIL edge63_64: got err=%b h=%b t=%0d want 1 1 4000", bus.wr_err, bus.rd_hit, bus.rd_target); end
    start_load(100, ld_cnt_t'(2));
    for (int i = 0; i < 2; i++) begin
      send_beat(pc_t'(i + 1), ok);
      n_tests++; if (!ok || bus.wr_err !== 1'b1) begin
        n_fail++; $display("FAIL stream_err%0d: got ok=%b err=%b want 1 1", i, ok, bus.wr_err); end
    end
    n_tests++; if (bus.ld_done !== 1'b1) begin n_fail++; $display("FAIL oob_done: got %b want 1", bus.ld_done); end
    step();
    start_load(0, ld_cnt_t'(0));
    n_tests++; if (bus.ld_done !== 1'b1 || bus.ld_busy !== 1'b0) begin
      n_fail++; $display("FAIL zero_count: got done=%b busy=%b want 1 0", bus.ld_done, bus.ld_busy); end
    step();
    n_tests++; if (bus.ld_done !== 1'b0) begin n_fail++; $display("FAIL zero_count_pulse: got %b want 0", bus.ld_done); end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc == 300) begin
        rst_n = 0; #1; model_reset(); #1; rst_n = 1;
      end
      bus.rd_en     = ($urandom_range(0, 1) == 1);
      bus.rd_label  = LUT_LABEL_W'($urandom_range(0, 79));
      bus.wr_en     = ($urandom_range(0, 3) == 0);
      bus.wr_label  = LUT_LABEL_W'($urandom_range(0, 79));
      bus.wr_target = pc_t'($urandom);
      bus.clr       = ($urandom_range(0, 39) == 0);
      bus.ld_start  = ($urandom_range(0, 7) == 0);
      bus.ld_base   = ($urandom_range(0, 3) == 0) ? LUT_LABEL_W'($urandom_range(250, 255)) : LUT_LABEL_W'($urandom_range(0, 70));
      bus.ld_count  = ld_cnt_t'($urandom_range(0, 5));
      bus.ld_valid  = ($urandom_range(0, 1) == 1);
      bus.ld_target = pc_t'($urandom);
      #1;
      n_tests++; if (bus.ld_ready !== (m_active && !bus.wr_en)) begin
        n_fail++; $display("FAIL rnd_ready@%0d: got %b want %b", cyc, bus.ld_ready, m_active && !bus.wr_en); end
      step();
      n_tests++; if (bus.rd_valid !== e_rv || bus.wr_err !== e_err || bus.ld_busy !== m_active || bus.ld_done !== m_finishing) begin
        n_fail++; $display("FAIL rnd_flags@%0d: got v=%b err=%b busy=%b done=%b want %b %b %b %b",
                           cyc, bus.rd_valid, bus.wr_err, bus.ld_busy, bus.ld_done, e_rv, e_err, m_active, m_finishing); end
      if (e_rv) begin
        n_tests++; if (bus.rd_hit !== e_hit || bus.rd_target !== e_tgt) begin
          n_fail++; $display("FAIL rnd_read@%0d: got h=%b t=%0d want h=%b t=%0d", cyc, bus.rd_hit, bus.rd_target, e_hit, e_tgt); end
      end
    end
    idle_inputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_bypass();
    test_stream();
    test_wrap();
    test_stall();
    test_clr_abort();
    test_err();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lut_prog.md
Name: lut_prog

Overview:
- Runtime-programmable branch-target table, the successor to the fixed label-to-PC lookup used by the fetch stage.
- A branch label indexes a table of PC targets. Software writes entries one at a time, or a loader streams a contiguous block of them.
- Per-entry valid bits give a hit/miss indication. The read port is registered, with one cycle of latency.

Parameters:
- LABEL_W, 8, width of the label and index.
- PC_W, 12, width of a target PC.
- DEPTH, 64, number of entries; must be ≤ 2**LABEL_W.
- DEFAULT_PC, 0, target returned on a miss.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- rd_en  in  1  lookup request.
- rd_label  in  LABEL_W  label to look up.
- rd_valid  out  1  lookup result valid (one cycle after rd_en).
- rd_hit  out  1  entry was valid.
- rd_target  out  PC_W  next_pc; equals DEFAULT_PC on a miss.
- wr_en  in  1  single-entry write.
- wr_label  in  LABEL_W  write index.
- wr_target  in  PC_W  write data.
- wr_err  out  1  one-cycle pulse: write (port or stream) to a label ≥ DEPTH.
- clr  in  1  invalidate all entries.
- ld_start  in  1  begin a stream load.
- ld_base  in  LABEL_W  first index of the stream.
- ld_count  in  LABEL_W+1  number of beats.
- ld_valid  in  1  stream beat valid.
- ld_target  in  PC_W  stream beat data.
- ld_ready  out  1  stream beat accepted when ld_valid & ld_ready.
- ld_busy  out  1  loader active.
- ld_done  out  1  one-cycle pulse at the end of a load.

Behaviour:

Reset (rst_n low, asynchronous):
- All valid bits cleared; FSM returns to IDLE.
- rd_valid, rd_hit, wr_err, ld_ready, ld_busy and ld_done are 0; rd_target is DEFAULT_PC.
- Target storage is not reset.

Read:
- rd_valid is rd_en delayed by one cycle.
- rd_hit and rd_target reflect table state after that cycle's writes (write-to-read bypass).
- A label ≥ DEPTH is always a miss.

Write priority, highest first:
1. clr: clears all valid bits. A read in the same cycle returns a miss.
2. Accepted stream beat.
3. wr_en.
- A port write or stream beat to an index < DEPTH stores the target and sets the valid bit.
- An index ≥ DEPTH stores nothing and pulses wr_err in the next cycle.

Loader FSM (states IDLE, LOAD, DONE):
- IDLE, on ld_start: latch ptr = ld_base and rem = ld_count. Go to LOAD if ld_count ≠ 0, else go to DONE.
- LOAD:
  - ld_busy = 1 and ld_ready = !wr_en (a port write stalls the stream).
  - Each accepted beat writes entry[ptr]; ptr increments and wraps DEPTH-1 → 0; rem decrements.
  - When rem reaches 0 on a beat, go to DONE.
- DONE: ld_done = 1 for exactly one cycle, then IDLE.
- Ignored conditions:
  - ld_start outside IDLE.
  - ld_valid while ld_ready = 0.
  - A ld_base ≥ DEPTH: beats pulse wr_err and ptr still increments. The wrap applies only when ptr = DEPTH-1; the field is LABEL_W bits and wraps naturally.
- clr while in LOAD or DONE: aborts to IDLE; ld_done is not asserted for an aborted load.
- Reset mid-load: immediate IDLE; the partial contents are lost with the valid bits.

Decomposition:
- Shared package lut_pkg holds:
  - The loader state enum (IDLE, LOAD, DONE).
  - Default LABEL_W, PC_W, DEPTH and DEFAULT_PC constants.
  - A ld_cnt_t typedef.
- Sub-module lut_load_ctrl holds the FSM, ptr and rem counters and the ld_ready/ld_busy/ld_done handshake.
  - It emits a write strobe, an index and data to the table.
- The top level holds storage, valid bits, the priority mux, bypass and read registers.

Test Plan (default parameters):
- Reset, then rd_en with label 2 → next cycle rd_valid=1, rd_hit=0, rd_target=0.
- wr_en label 2 = 352 with rd_en label 2 in the same cycle → next cycle rd_hit=1, rd_target=352 (bypass). Label 3 still misses.
- ld_start with base 18, count 3; beats 8, 22, 37 with one idle cycle between beats 2 and 3 → ld_done pulses once after the last beat. Labels 18/19/20 read 8/22/37; ld_busy=0 afterwards.
- Wrap: ld_start with base 62, count 4; beats 1, 2, 3, 4 → entries 62, 63, 0, 1 = 1, 2, 3, 4; entry 2 stays a miss.
- During LOAD, hold wr_en on label 5 for one cycle while ld_valid=1 → ld_ready=0 that cycle and no beat is lost. Label 5 is written; the stream completes with the correct count.
- Other cases:
  - clr two beats into a count-4 load → FSM IDLE, no ld_done, every label misses.
  - Write to label 70 → wr_err pulses and a read of label 70 misses.
